vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VGA timing generator. Samples HSync/VSync/Blank/RGB,

---
 rtl/vga_sync_decoder.sv | 198 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA raster receiver: measures sync timing, locks onto a stable raster
// and emits per-pixel coordinates together with the captured colour.
module vga_sync_decoder #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter bit SYNC_ACT_LOW = 1'b1,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk_VGA,
  input  logic        rst,
  input  logic        HSync,
  input  logic        VSync,
  input  logic        Blank,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [10:0] h_meas
);

  localparam logic [1:0]  S_SEARCH = 2'd0;
  localparam logic [1:0]  S_TRACK  = 2'd1;
  localparam logic [1:0]  S_LOCKED = 2'd2;

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [9:0]  VT = 10'(V_TOTAL);
  localparam logic [9:0]  HA = 10'(H_ACTIVE);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);
  localparam logic [2:0]  LF = 3'(LOCK_FRAMES);
  localparam logic        INV = SYNC_ACT_LOW;

  logic        s1_hs, s1_vs, s1_blank;
  logic        hs_prev, vs_prev;
  logic [7:0]  s1_r, s1_g, s1_b;

  logic [10:0] h_cnt, h_nxt;
  logic [9:0]  line_cnt, line_inc;
  logic [9:0]  act_x, act_y;
  logic [9:0]  x_cur, y_cur, x_nxt;

  logic [1:0]  state, state_nxt;
  logic [2:0]  good, good_nxt, good_inc;
  logic        bad_flag, bad_nxt;
  logic        hs_seen, seen_nxt;

  logic        hs_edge, vs_edge;
  logic        line_bad, act_bad, mism;
  logic        frame_ok, err, pix_ok;

  always_comb begin
    hs_edge  = s1_hs & ~hs_prev;
    vs_edge  = s1_vs & ~vs_prev;

    h_nxt    = hs_edge ? 11'd1 :
               (&h_cnt) ? h_cnt : h_cnt + 11'd1;
    line_inc = (hs_edge && !(&line_cnt)) ?
               line_cnt + 10'd1 : line_cnt;

    // coordinates of the pixel in stage 1, after this cycle's sync edges
    x_cur = hs_edge ? 10'd0 : act_x;
    if (vs_edge)
      y_cur = 10'd0;
    else if (hs_edge && act_x != 10'd0 && !(&act_y))
      y_cur = act_y + 10'd1;
    else
      y_cur = act_y;
    x_nxt = (s1_blank && !(&x_cur)) ? x_cur + 10'd1 : x_cur;

    line_bad = hs_edge & hs_seen & (h_cnt != HT);
    act_bad  = s1_blank & ((x_cur >= HA) | (y_cur >= VA));
    mism     = line_bad | act_bad;
    frame_ok = (line_inc == VT) & ~bad_flag & ~mism;
    pix_ok   = (state == S_LOCKED) & s1_blank;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    good_inc  = good + 3'd1;
    bad_nxt   = bad_flag;
    seen_nxt  = hs_seen | hs_edge;
    err       = 1'b0;
    case (state)
      S_SEARCH: begin
        if (vs_edge) begin
          state_nxt = S_TRACK;
          good_nxt  = 3'd0;
          bad_nxt   = 1'b0;
          seen_nxt  = 1'b0;
        end
      end
      S_TRACK: begin
        bad_nxt = bad_flag | mism;
        err     = mism;
        if (vs_edge) begin
          bad_nxt = 1'b0;
          if (frame_ok) begin
            good_nxt = good_inc;
            if (good_inc >= LF)
              state_nxt = S_LOCKED;
          end else begin
            good_nxt = 3'd0;
            err      = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        bad_nxt = 1'b0;
        if (mism || (vs_edge && !frame_ok)) begin
          err       = 1'b1;
          state_nxt = S_SEARCH;
        end
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk_VGA or posedge rst) begin
    if (rst) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b0;
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      s1_r     <= 8'd0;
      s1_g     <= 8'd0;
      s1_b     <= 8'd0;
      h_cnt    <= 11'd0;
      line_cnt <= 10'd0;
      act_x    <= 10'd0;
      act_y    <= 10'd0;
      state    <= S_SEARCH;
      good     <= 3'd0;
      bad_flag <= 1'b0;
      hs_seen  <= 1'b0;
    end else begin
      s1_hs    <= HSync ^ INV;
      s1_vs    <= VSync ^ INV;
      s1_blank <= Blank;
      hs_prev  <= s1_hs;
      vs_prev  <= s1_vs;
      s1_r     <= R;
      s1_g     <= G;
      s1_b     <= B;
      h_cnt    <= h_nxt;
      line_cnt <= vs_edge ? 10'd0 : line_inc;
      act_x    <= x_nxt;
      act_y    <= y_cur;
      state    <= state_nxt;
      good     <= good_nxt;
      bad_flag <= bad_nxt;
      hs_seen  <= seen_nxt;
    end
  end

  always_ff @(posedge clk_VGA or posedge rst) begin
    if (rst) begin
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      pixel_valid <= 1'b0;
      pix_R       <= 8'd0;
      pix_G       <= 8'd0;
      pix_B       <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      h_meas      <= 11'd0;
    end else begin
      pixel_valid <= pix_ok;
      if (pix_ok) begin
        pixel_x <= x_cur;
        pixel_y <= y_cur;
        pix_R   <= s1_r;
        pix_G   <= s1_g;
        pix_B   <= s1_b;
      end
      line_start  <= hs_edge;
      frame_start <= vs_edge;
      locked      <= (state_nxt == S_LOCKED);
      timing_err  <= err;
      if (hs_edge)
        h_meas <= h_cnt;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: reduced raster driven into an active-low
// and an active-high sync instance, outputs checked against a queue.
module tb_vga_sync_decoder;

  localparam int H_A = 16;
  localparam int V_A = 8;
  localparam int H_T = 40;
  localparam int V_T = 20;

  typedef struct packed {
    logic        v;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        ls;
    logic        fs;
    logic        lk;
    logic        er;
    logic        hk;
    logic [10:0] hm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hs_n = 1'b1, vs_n = 1'b1;
  logic hs_p = 1'b0, vs_p = 1'b0;
  logic blank = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;

  logic [9:0]  px_l, py_l, px_h, py_h;
  logic        pv_l, pv_h, ls_l, ls_h, fs_l, fs_h;
  logic        lk_l, lk_h, er_l, er_h;
  logic [7:0]  pr_l, pg_l, pb_l, pr_h, pg_h, pb_h;
  logic [10:0] hm_l, hm_h;
  logic [48:0] out_l, out_h;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [9:0]  hx, hy;
  logic [7:0]  hr, hg, hb;
  logic        cur_lk, cur_hk, have_edge;
  logic [10:0] cur_hm;
  int          last_len;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_TOTAL(H_T), .V_TOTAL(V_T),
    .SYNC_ACT_LOW(1'b1), .LOCK_FRAMES(2)
  ) dut_l (
    .clk_VGA(clk), .rst(rst), .HSync(hs_n), .VSync(vs_n),
    .Blank(blank), .R(r), .G(g), .B(b),
    .pixel_x(px_l), .pixel_y(py_l), .pixel_valid(pv_l),
    .pix_R(pr_l), .pix_G(pg_l), .pix_B(pb_l),
    .line_start(ls_l), .frame_start(fs_l), .locked(lk_l),
    .timing_err(er_l), .h_meas(hm_l)
  );

  vga_sync_decoder #(
    .H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_TOTAL(H_T), .V_TOTAL(V_T),
    .SYNC_ACT_LOW(1'b0), .LOCK_FRAMES(2)
  ) dut_h (
    .clk_VGA(clk), .rst(rst), .HSync(hs_p), .VSync(vs_p),
    .Blank(blank), .R(r), .G(g), .B(b),
    .pixel_x(px_h), .pixel_y(py_h), .pixel_valid(pv_h),
    .pix_R(pr_h), .pix_G(pg_h), .pix_B(pb_h),
    .line_start(ls_h), .frame_start(fs_h), .locked(lk_h),
    .timing_err(er_h), .h_meas(hm_h)
  );

  assign out_l = {pv_l, px_l, py_l, pr_l, pg_l, pb_l,
                  ls_l, fs_l, lk_l, er_l};
  assign out_h = {pv_h, px_h, py_h, pr_h, pg_h, pb_h,
                  ls_h, fs_h, lk_h, er_h};

  task automatic reset_model();
    sb.delete();
    hx = '0; hy = '0;
    hr = '0; hg = '0; hb = '0;
    cur_lk = 1'b0;
    cur_hm = '0;
    cur_hk = 1'b1;
    have_edge = 1'b0;
    last_len = 0;
  endtask

  task automatic drive_cycle(
    input logic hs, input logic vs, input logic bl,
    input logic [7:0] rr, input logic [7:0] gg,
    input logic [7:0] bb, input logic v,
    input logic ls, input logic fs, input logic er
  );
    exp_t e, p;
    logic [59:0] ev, gl, gh;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 2) begin
      p  = sb.pop_front();
      ev = {p.v, p.x, p.y, p.r, p.g, p.b, p.ls, p.fs, p.lk, p.er,
            p.hk ? p.hm : 11'd0};
      gl = {out_l, p.hk ? hm_l : 11'd0};
      gh = {out_h, p.hk ? hm_h : 11'd0};
      n_cmp += 2;
      if (gl !== ev) begin
        n_bad++;
        $display("FAIL sb_low cyc %0d got %h exp %h", cyc, gl, ev);
      end
      if (gh !== ev) begin
        n_bad++;
        $display("FAIL sb_high cyc %0d got %h exp %h", cyc, gh, ev);
      end
    end
    hs_n = ~hs; hs_p = hs;
    vs_n = ~vs; vs_p = vs;
    blank = bl;
    r = rr; g = gg; b = bb;
    e.v = v; e.x = hx; e.y = hy;
    e.r = hr; e.g = hg; e.b = hb;
    e.ls = ls; e.fs = fs; e.lk = cur_lk; e.er = er;
    e.hk = cur_hk; e.hm = cur_hm;
    sb.push_back(e);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);
  endtask

  // lk0/er0: locked and timing_err expected at this frame's VSync edge;
  // sl: index of a line one cycle short; max_cyc: stop early if > 0
  task automatic drive_frame(
    input int nl, input logic lk0, input logic er0,
    input int sl, input int max_cyc
  );
    int n = 0;
    for (int ln = 0; ln < nl; ln++) begin
      int len = (ln == sl) ? H_T - 1 : H_T;
      for (int c = 0; c < len; c++) begin
        logic bl, v, er;
        logic [7:0] rr, gg, bb;
        if (max_cyc > 0 && n == max_cyc) return;
        n++;
        bl = (ln >= 3) && (ln < 3 + V_A) && (c >= 8) && (c < 8 + H_A);
        v  = cur_lk & bl;
        er = 1'b0;
        rr = 8'd0; gg = 8'd0; bb = 8'd0;
        if (bl) begin
          rr = 8'($urandom_range(0, 255));
          gg = 8'($urandom_range(0, 255));
          bb = 8'($urandom_range(0, 255));
          if (ln == 3 && c == 8) begin
            rr = 8'hAA; gg = 8'h55; bb = 8'h0F;
          end
        end
        if (c == 0) begin
          cur_hk = have_edge;
          if (have_edge) cur_hm = 11'(last_len);
          have_edge = 1'b1;
          if (ln == 0) begin
            cur_lk = lk0;
            er = er0;
          end
          if (sl >= 0 && ln == sl + 1) begin
            cur_lk = 1'b0;
            er = 1'b1;
          end
        end
        if (v) begin
          hx = 10'(c - 8); hy = 10'(ln - 3);
          hr = rr; hg = gg; hb = bb;
        end
        drive_cycle(c < 4, ln < 2, bl, rr, gg, bb, v,
                    c == 0, ln == 0 && c == 0, er);
      end
      last_len = len;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp += 2;
    if ({out_l, hm_l} !== 60'd0) begin
      n_bad++;
      $display("FAIL reset_low got %h exp 0", {out_l, hm_l});
    end
    if ({out_h, hm_h} !== 60'd0) begin
      n_bad++;
      $display("FAIL reset_high got %h exp 0", {out_h, hm_h});
    end
    reset_model();
    @(negedge clk) rst = 1'b0;
    drive_idle(4);
  endtask

  task automatic test_lock();
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 1, 0, -1, 0);
    n_cmp += 2;
    if ({lk_l, lk_h} !== 2'b11) begin
      n_bad++;
      $display("FAIL lock got %b exp 11", {lk_l, lk_h});
    end
    if (hm_l !== 11'(H_T)) begin
      n_bad++;
      $display("FAIL h_meas got %0d exp %0d", hm_l, H_T);
    end
  endtask

  task automatic test_pixels();
    drive_frame(V_T, 1, 0, -1, 0);
    n_cmp++;
    if ({px_l, py_l, pr_l} !== {10'(H_A - 1), 10'(V_A - 1), hr}) begin
      n_bad++;
      $display("FAIL last_pixel got %0d,%0d,%h exp %0d,%0d,%h",
               px_l, py_l, pr_l, H_A - 1, V_A - 1, hr);
    end
  endtask

  task automatic test_short_line();
    drive_frame(V_T, 1, 0, 15, 0);
    n_cmp++;
    if (lk_l !== 1'b0) begin
      n_bad++;
      $display("FAIL unlock got %b exp 0", lk_l);
    end
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 1, 0, -1, 0);
    n_cmp++;
    if (lk_h !== 1'b1) begin
      n_bad++;
      $display("FAIL relock got %b exp 1", lk_h);
    end
  endtask

  task automatic test_mid_reset();
    drive_frame(V_T, 1, 0, -1, 5 * H_T + 15);
    #2 rst = 1'b1;
    hs_n = 1'b1; vs_n = 1'b1;
    hs_p = 1'b0; vs_p = 1'b0;
    blank = 1'b0;
    #1;
    n_cmp += 2;
    if ({out_l, hm_l} !== 60'd0) begin
      n_bad++;
      $display("FAIL mid_reset_low got %h exp 0", {out_l, hm_l});
    end
    if ({out_h, hm_h} !== 60'd0) begin
      n_bad++;
      $display("FAIL mid_reset_high got %h exp 0", {out_h, hm_h});
    end
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    drive_idle(4);
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 1, 0, -1, 0);
  endtask

  task automatic test_short_frame();
    drive_frame(V_T, 1, 0, 15, 0);
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T - 1, 0, 0, -1, 0);
    drive_frame(V_T, 0, 1, -1, 0);
    drive_frame(V_T, 0, 0, -1, 0);
    drive_frame(V_T, 1, 0, -1, 0);
    drive_idle(4);
    n_cmp++;
    if ({lk_l, lk_h} !== 2'b11) begin
      n_bad++;
      $display("FAIL final_lock got %b exp 11", {lk_l, lk_h});
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_lock();
    test_pixels();
    test_short_line();
    test_mid_reset();
    test_short_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
